// File: rtl/sbox_sched_pkg.sv
// Shared types and defaults for the masked S-box pipeline scheduler.
// Optional feature macro: SBOX_SCHED_ZEROIZE_EN (see sbox_pipeline_scheduler.sv).
package sbox_sched_pkg;

  // FSM states
  //   state | meaning
  //   IDLE  | waiting for start, results/state held
  //   ISSUE | feeding one nibble per cycle that has randomness available
  //   DRAIN | all nibbles issued, waiting for the last S-box results
  //   DONE  | results valid, waiting for ack
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LAT_DEF = 2;
  localparam int NIB_DEF = 16;

  // Tag index is wide enough for any practical nibble count (up to 255).
  localparam int IDX_W = 8;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/sbox_sched_tagpipe.sv
// LAT-deep shift register of {valid, idx} tags, mirroring the latency of the
// external masked S-box so each result can be written to the right nibble.
module sbox_sched_tagpipe
  import sbox_sched_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe [LAT];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign tag_out = pipe[LAT-1];

endmodule

// File: rtl/sbox_pipeline_scheduler.sv
// Schedules the nibbles of a two-share state through an external masked
// S-box of latency LAT, one nibble per cycle with fresh randomness.
// Optional macro SBOX_SCHED_ZEROIZE_EN: blank sbox_in outside issue cycles and
// wipe results and captured state after ack.
module sbox_pipeline_scheduler
  import sbox_sched_pkg::*;
#(
  parameter int LAT = LAT_DEF,
  parameter int NIB = NIB_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NIB-1:0]  state_s0,
  input  logic [4*NIB-1:0]  state_s1,
  input  logic [63:0]       rnd_in,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  output logic [3:0]        sbox_in_s0,
  output logic [3:0]        sbox_in_s1,
  output logic [63:0]       sbox_fresh,
  input  logic [3:0]        sbox_out_s0,
  input  logic [3:0]        sbox_out_s1,
  output logic [4*NIB-1:0]  res_s0,
  output logic [4*NIB-1:0]  res_s1,
  output logic              busy,
  output logic              done,
  input  logic              ack
);

  localparam int W     = 4*NIB;
  localparam int CNT_W = $clog2(NIB+1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB-1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NIB);

  state_t           state_q, state_d;
  logic [W-1:0]     cap_s0, cap_s1;
  logic [W-1:0]     res_q0, res_q1;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             issue, capture, ack_take;
  logic [3:0]       cur0, cur1;
  tag_t             tag_in, tag_out;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    capture  = 1'b0;
    ack_take = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy  = 1'b1;
        issue = rnd_valid;
        if (rnd_valid && idx_q == IDX_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (cnt_q == CNT_FULL) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (ack) begin
          ack_take = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the nibble at the current issue index from the captured shares.
  always_comb begin
    cur0 = '0;
    cur1 = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur0 = cap_s0[4*i +: 4];
        cur1 = cap_s1[4*i +: 4];
      end
    end
  end

  assign rnd_ready  = issue;
  assign sbox_fresh = rnd_in;
  assign tag_in     = '{valid: issue, idx: idx_q};

  sbox_sched_tagpipe #(.LAT(LAT)) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Capture, issue index, and result collection keyed by emerging tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_s0 <= '0;
      cap_s1 <= '0;
      res_q0 <= '0;
      res_q1 <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (capture) begin
        cap_s0 <= state_s0;
        cap_s1 <= state_s1;
        res_q0 <= '0;
        res_q1 <= '0;
        idx_q  <= '0;
        cnt_q  <= '0;
      end
      if (issue) idx_q <= idx_q + IDX_W'(1);
      if (tag_out.valid && cnt_q != CNT_FULL) begin
        cnt_q <= cnt_q + CNT_W'(1);
        for (int i = 0; i < NIB; i++) begin
          if (tag_out.idx == IDX_W'(i)) begin
            res_q0[4*i +: 4] <= sbox_out_s0;
            res_q1[4*i +: 4] <= sbox_out_s1;
          end
        end
      end
`ifdef SBOX_SCHED_ZEROIZE_EN
      if (ack_take) begin
        res_q0 <= '0;
        res_q1 <= '0;
        cap_s0 <= '0;
        cap_s1 <= '0;
      end
`endif
    end
  end

`ifdef SBOX_SCHED_ZEROIZE_EN
  assign sbox_in_s0 = issue ? cur0 : 4'h0;
  assign sbox_in_s1 = issue ? cur1 : 4'h0;
`else
  logic [3:0] sin0_q, sin1_q;

  // Remember the last issued nibble so sbox_in holds between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin0_q <= '0;
      sin1_q <= '0;
    end else if (issue) begin
      sin0_q <= cur0;
      sin1_q <= cur1;
    end
  end

  assign sbox_in_s0 = issue ? cur0 : sin0_q;
  assign sbox_in_s1 = issue ? cur1 : sin1_q;
`endif

  assign res_s0 = res_q0;
  assign res_s1 = res_q1;

endmodule

// File: tb/tb_sbox_pipeline_scheduler.sv
// Scoreboard bench for sbox_pipeline_scheduler with a behavioural masked
// Skinny-64 S-box of latency LAT attached.
module tb_sbox_pipeline_scheduler;

  localparam int LAT = 2;
  localparam int NIB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] state_s0 = '0, state_s1 = '0;
  logic [63:0] rnd_in = '0;
  logic        rnd_valid = 1'b0;
  logic        rnd_ready;
  logic [3:0]  sbox_in_s0, sbox_in_s1;
  logic [63:0] sbox_fresh;
  logic [3:0]  sbox_out_s0, sbox_out_s1;
  logic [63:0] res_s0, res_s1;
  logic        busy, done;
  logic        ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] exp_q [$];
  int          lat_q [$];

  sbox_pipeline_scheduler #(.LAT(LAT), .NIB(NIB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .state_s0(state_s0), .state_s1(state_s1),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sbox_in_s0(sbox_in_s0), .sbox_in_s1(sbox_in_s1), .sbox_fresh(sbox_fresh),
    .sbox_out_s0(sbox_out_s0), .sbox_out_s1(sbox_out_s1),
    .res_s0(res_s0), .res_s1(res_s1),
    .busy(busy), .done(done), .ack(ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sb4(input logic [3:0] x);
    case (x)
      4'h0: return 4'hc; 4'h1: return 4'h6; 4'h2: return 4'h9; 4'h3: return 4'h0;
      4'h4: return 4'h1; 4'h5: return 4'ha; 4'h6: return 4'h2; 4'h7: return 4'hb;
      4'h8: return 4'h3; 4'h9: return 4'h8; 4'ha: return 4'h5; 4'hb: return 4'hd;
      4'hc: return 4'h4; 4'hd: return 4'he; 4'he: return 4'h7; default: return 4'hf;
    endcase
  endfunction

  function automatic logic [63:0] sub64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb4(x[4*i +: 4]);
    return r;
  endfunction

  // External masked S-box: LAT-cycle delay, output re-masked with fresh bits.
  logic [3:0] sp_v [LAT];
  logic [3:0] sp_m [LAT];
  always @(posedge clk) begin
    sp_v[0] <= sbox_in_s0 ^ sbox_in_s1;
    sp_m[0] <= sbox_fresh[3:0];
    for (int k = 1; k < LAT; k++) begin
      sp_v[k] <= sp_v[k-1];
      sp_m[k] <= sp_m[k-1];
    end
  end
  assign sbox_out_s1 = sp_m[LAT-1];
  assign sbox_out_s0 = sb4(sp_v[LAT-1]) ^ sp_m[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: checks every issued nibble and pops the scoreboard on done.
  initial begin : monitor
    logic [63:0] cur;
    logic [63:0] sh;
    logic        prev_done;
    int          ik;
    cur = '0; ik = 0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
        ik = 0;
      end else begin
        if (start && !busy && !done) begin
          cur = state_s0 ^ state_s1;
          ik  = 0;
        end
        if (rnd_ready) begin
          sh = cur >> (4*ik);
          check("issue_within_nib", 64'(ik < NIB), 64'd1);
          check("issue_nibble", 64'(sbox_in_s0 ^ sbox_in_s1), 64'(sh[3:0]));
          check("ready_only_with_valid", 64'(rnd_valid), 64'd1);
          ik++;
        end
        if (done && !prev_done) begin
          if (exp_q.size() == 0 || lat_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            check("result", res_s0 ^ res_s1, exp_q.pop_front());
            check("done_latency", 64'(cyc), 64'(lat_q.pop_front()));
            check("issue_count", 64'(ik), 64'(NIB));
          end
        end
        prev_done = done;
      end
    end
  end

  // mode 0: rnd_valid always 1; 1: toggling 1,0,1..; 2: random.
  // rst_after > 0 aborts the op with reset after that many issues.
  task automatic run_op(input logic [63:0] a0, input logic [63:0] a1, input int mode,
                        input bit disturb, input int rst_after);
    int issued, n;
    logic [63:0] exp_res;
    issued  = 0;
    n       = 0;
    exp_res = sub64(a0 ^ a1);
    @(posedge clk); #1;
    start = 1'b1; state_s0 = a0; state_s1 = a1; rnd_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (issued < NIB && n < 200) begin
      n++;
      rnd_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 1) : 1'($urandom_range(0, 1));
      rnd_in    = {$urandom, $urandom};
      if (disturb && n == 3) begin
        start = 1'b1;
        state_s0 = ~a0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (rnd_valid) issued++;
      if (rst_after > 0 && issued == rst_after) begin
        rst = 1'b1;
        rnd_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_res_s0", res_s0, 64'd0);
        check("rst_res_s1", res_s1, 64'd0);
        check("rst_sbox_in", 64'({sbox_in_s0, sbox_in_s1}), 64'd0);
        check("rst_ctrl", 64'({busy, done, rnd_ready}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    start = 1'b0;
    check("issue_timeout", 64'(issued), 64'(NIB));
    exp_q.push_back(exp_res);
    lat_q.push_back(cyc + LAT + 1);
    if (disturb) begin
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
    end
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", 64'(done), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_held", 64'(done), 64'd1);
    check("result_stable", res_s0 ^ res_s1, exp_res);
`ifndef SBOX_SCHED_ZEROIZE_EN
    check("sbox_in_holds_last", 64'(sbox_in_s0 ^ sbox_in_s1), 64'(exp_res[63:60] ^ exp_res[63:60] ^ (a0[63:60] ^ a1[63:60])));
`endif
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    check("after_ack_idle", 64'({busy, done}), 64'd0);
`ifdef SBOX_SCHED_ZEROIZE_EN
    check("zeroize_res", res_s0 | res_s1, 64'd0);
    check("zeroize_sbox_in", 64'({sbox_in_s0, sbox_in_s1}), 64'd0);
`endif
  endtask

  initial begin : driver
    logic [63:0] m;
    @(negedge clk);
    check("reset_res", res_s0 | res_s1, 64'd0);
    check("reset_ctrl", 64'({busy, done, rnd_ready, sbox_in_s0, sbox_in_s1}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(64'h0123456789ABCDEF, 64'd0, 0, 1'b0, 0);
    m = {$urandom, $urandom};
    run_op(64'h0123456789ABCDEF ^ m, m, 1, 1'b0, 0);
    m = {$urandom, $urandom};
    run_op(64'h0123456789ABCDEF ^ m, m, 0, 1'b0, 0);
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 2, 1'b1, 0);
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 7);
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 0);
    for (int t = 0; t < 4; t++)
      run_op({$urandom, $urandom}, {$urandom, $urandom}, t % 3, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
